key_event_fifo: RTL and testbench
=================================

# key_event_fifo

Keyboard front-end stage between `KeyboardDecoder` and the vending-machine controller. Turns the decoder's raw `key_down`/`last_change`/`key_valid` outputs into clean single-press events: digit 0–9, enter, space, backspace. Events are queued in a small FIFO and drained by the controller through a valid/ready handshake. The stage rejects typematic repeats, key releases and multi-key chords, so the controller never recomputes `pre_key_down` filtering itself.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.

Ports:
- `clk` in 1: system clock (100 MHz).
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_down` in 512: decoder key-held vector, indexed by extended scan code.
- `last_change` in 9: decoder scan code of the most recent make or break.
- `key_valid` in 1: decoder one-cycle strobe; `last_change`/`key_down` updated.
- `evt_ready` in 1: consumer accepts the head event this cycle.
- `ovf_clr` in 1: clears the sticky `overflow` flag.
- `evt_valid` out 1: FIFO non-empty.
- `evt_code` out 4: head event; 0–9 = digit, 10 = enter, 11 = space, 12 = backspace.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.

## Operation

- **Press qualification.** A press is qualified in a cycle when all of the following hold:
  - `key_valid` is high;
  - `key_down[last_change]` is 1;
  - `key_down` equals one-hot(`last_change`), i.e. exactly one key is held;
  - `key_down` differs from `prev_key_down`.
- **Register `prev_key_down`.** 512 bits; loaded with `key_down` every cycle.
- **Rejected inputs.** Break codes, typematic repeats (unchanged `key_down`) and chords produce no event.
- **Classification.** Combinational from `last_change`:
  - top-row digits 0x45, 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46 map to 0–9;
  - 0x5A maps to 10, 0x29 to 11, 0x66 to 12;
  - any other code is unmapped and is discarded with no push.
- **Push.** A qualified, mapped press writes its code at the tail.
- **Pop.** Occurs when `evt_valid && evt_ready`; the head advances.
- **Simultaneous push and pop:**
  - not full: both happen, `count` unchanged;
  - full: both happen, the new entry is accepted and `count` stays `DEPTH`;
  - empty: push only, no bypass; `evt_ready` is ignored while `evt_valid` is 0.
- **Overflow.** Push while full with no pop drops the new event, preserves FIFO contents, and sets `overflow`.
- **Flag priority.** `ovf_clr` clears `overflow`. If `ovf_clr` coincides with a new drop, set wins.
- **Pointer wrap.** Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Full/empty are derived from `count`.

## Timing

- **Reset (`rst_n` low).** Asynchronous. `evt_valid`=0, `evt_code`=0, `count`=0, `overflow`=0, pointers=0, `prev_key_down`=0. Storage contents are don't-care.
- **Reset mid-operation.** All queued events are lost. The first qualified press after release is accepted normally.
- **Push latency.**
  - A qualified `key_valid` in cycle N writes at the edge ending N.
  - `evt_valid`=1 and `evt_code` valid in cycle N+1.
- **Pop.**
  - Handshake in cycle M makes the next entry visible in M+1.
  - `evt_code` is registered head data and is stable while `evt_valid && !evt_ready`.
- **Throughput.** One push and one pop per cycle, sustained.
- **Overflow.** `overflow` rises the cycle after the dropping edge.

## Configuration

- **Macro `KEY_EVENT_KEYPAD_EN`.**
  - Defined: numeric-keypad codes also map to digits. 0x70→0, 0x69→1, 0x72→2, 0x7A→3, 0x6B→4, 0x73→5, 0x74→6, 0x6C→7, 0x75→8, 0x7D→9.
  - Undefined: these codes are unmapped and discarded. Qualification logic is unchanged, so a keypad press still updates `prev_key_down`.

## Structure

- **Package `key_event_pkg`.**
  - Scan-code localparams: `SC_ENTER`, `SC_SPACE`, `SC_BKSP`, the top-row digit codes and the keypad digit codes.
  - Event-code constants: `EVT_ENTER`=10, `EVT_SPACE`=11, `EVT_BKSP`=12.
  - Function `scan_to_evt` returning {mapped, code[3:0]}.
- **Sub-module `event_fifo`.** Generic synchronous FIFO with parameters `WIDTH` and `DEPTH`. Provides push/pop, `count` and `full`/`empty`, implementing the simultaneous-event rules above. `key_event_fifo` contains only qualification, classification and overflow logic.

## Test plan

- **Single press.** Press 0x16, then its break 0xF0 0x16. Expect exactly one event `evt_code`=1, asserted one cycle after the make `key_valid`; the break produces no event.
- **Typematic repeat.** Hold 0x5A through three repeated make strobes. Expect a single event 10.
- **Chord.** Hold 0x16, then press 0x1E. Expect event 1 only; no event for 2. Release both, press 0x1E. Expect event 2.
- **Overflow.** With `evt_ready`=0, push 5 digits 3,4,5,6,7 (DEPTH=4). Expect `count`=4, `overflow`=1 and drain order 3,4,5,6. Pulse `ovf_clr`: `overflow` returns to 0.
- **Full with simultaneous pop.** Fill with 1,2,3,4; on the cycle of the next push 9, hold `evt_ready`=1. Expect `count` stays 4, `overflow`=0, order 2,3,4,9.
- **Keypad and reset.** Press 0x70. Expect event 0 with the macro defined and no event without it. Assert `rst_n` low with 2 entries queued: expect `evt_valid`=0 and `count`=0 immediately, asynchronously.

Source files
------------

// File: rtl/key_event_pkg.sv
// Scan-code and event-code constants plus the scan-code classifier for the key event stage.
// Keypad digit mapping is compiled in only when KEY_EVENT_KEYPAD_EN is defined.
package key_event_pkg;

    localparam int unsigned KEY_W  = 512;
    localparam int unsigned CODE_W = 9;

    localparam logic [8:0] SC_ENTER = 9'h05A;
    localparam logic [8:0] SC_SPACE = 9'h029;
    localparam logic [8:0] SC_BKSP  = 9'h066;

    localparam logic [8:0] SC_D0 = 9'h045;
    localparam logic [8:0] SC_D1 = 9'h016;
    localparam logic [8:0] SC_D2 = 9'h01E;
    localparam logic [8:0] SC_D3 = 9'h026;
    localparam logic [8:0] SC_D4 = 9'h025;
    localparam logic [8:0] SC_D5 = 9'h02E;
    localparam logic [8:0] SC_D6 = 9'h036;
    localparam logic [8:0] SC_D7 = 9'h03D;
    localparam logic [8:0] SC_D8 = 9'h03E;
    localparam logic [8:0] SC_D9 = 9'h046;

    localparam logic [8:0] SC_KP0 = 9'h070;
    localparam logic [8:0] SC_KP1 = 9'h069;
    localparam logic [8:0] SC_KP2 = 9'h072;
    localparam logic [8:0] SC_KP3 = 9'h07A;
    localparam logic [8:0] SC_KP4 = 9'h06B;
    localparam logic [8:0] SC_KP5 = 9'h073;
    localparam logic [8:0] SC_KP6 = 9'h074;
    localparam logic [8:0] SC_KP7 = 9'h06C;
    localparam logic [8:0] SC_KP8 = 9'h075;
    localparam logic [8:0] SC_KP9 = 9'h07D;

    localparam logic [3:0] EVT_ENTER = 4'd10;
    localparam logic [3:0] EVT_SPACE = 4'd11;
    localparam logic [3:0] EVT_BKSP  = 4'd12;

    // Returns {mapped, code}; mapped=0 means the press is discarded.
    function automatic logic [4:0] scan_to_evt(input logic [8:0] sc);
        logic [4:0] r;
        r = '0;
        case (sc)
            SC_D0:    r = {1'b1, 4'd0};
            SC_D1:    r = {1'b1, 4'd1};
            SC_D2:    r = {1'b1, 4'd2};
            SC_D3:    r = {1'b1, 4'd3};
            SC_D4:    r = {1'b1, 4'd4};
            SC_D5:    r = {1'b1, 4'd5};
            SC_D6:    r = {1'b1, 4'd6};
            SC_D7:    r = {1'b1, 4'd7};
            SC_D8:    r = {1'b1, 4'd8};
            SC_D9:    r = {1'b1, 4'd9};
            SC_ENTER: r = {1'b1, EVT_ENTER};
            SC_SPACE: r = {1'b1, EVT_SPACE};
            SC_BKSP:  r = {1'b1, EVT_BKSP};
`ifdef KEY_EVENT_KEYPAD_EN
            SC_KP0:   r = {1'b1, 4'd0};
            SC_KP1:   r = {1'b1, 4'd1};
            SC_KP2:   r = {1'b1, 4'd2};
            SC_KP3:   r = {1'b1, 4'd3};
            SC_KP4:   r = {1'b1, 4'd4};
            SC_KP5:   r = {1'b1, 4'd5};
            SC_KP6:   r = {1'b1, 4'd6};
            SC_KP7:   r = {1'b1, 4'd7};
            SC_KP8:   r = {1'b1, 4'd8};
            SC_KP9:   r = {1'b1, 4'd9};
`endif
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
// Occupancy is tracked explicitly and drives full/empty; pointers wrap modulo DEPTH.
module event_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/key_event_fifo.sv
// Qualifies single-key presses from the keyboard decoder, classifies them, and queues events.
// Defining KEY_EVENT_KEYPAD_EN additionally maps numeric-keypad digits.
module key_event_fifo
    import key_event_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [511:0]             key_down,
    input  logic [8:0]               last_change,
    input  logic                     key_valid,
    input  logic                     evt_ready,
    input  logic                     ovf_clr,
    output logic                     evt_valid,
    output logic [3:0]               evt_code,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    logic [KEY_W-1:0] prev_key_down;
    logic [KEY_W-1:0] one_hot;
    logic [4:0]       cls;
    logic             qualified;
    logic             push_req;
    logic             drop;
    logic             full;
    logic             empty;
    logic [3:0]       head;

    assign one_hot   = KEY_W'(1) << last_change;
    assign qualified = key_valid && key_down[last_change]
                       && (key_down == one_hot) && (key_down != prev_key_down);
    assign cls       = scan_to_evt(last_change);
    assign push_req  = qualified && cls[4];
    // A full FIFO only refuses the push when nothing is leaving this cycle.
    assign drop      = push_req && full && !evt_ready;

    assign evt_valid = !empty;
    assign evt_code  = evt_valid ? head : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_key_down <= '0;
            overflow      <= 1'b0;
        end else begin
            prev_key_down <= key_down;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    event_fifo #(
        .WIDTH (4),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (evt_ready),
        .wdata (cls[3:0]),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_key_event_fifo.sv
// Scoreboard bench: stimulus queues hand-computed event codes; a monitor checks each handshake.
module tb_key_event_fifo;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [511:0] key_down = '0;
    logic [8:0]   last_change = '0;
    logic         key_valid = 1'b0;
    logic         evt_ready = 1'b0;
    logic         ovf_clr = 1'b0;
    logic         evt_valid;
    logic [3:0]   evt_code;
    logic [2:0]   count;
    logic         overflow;

    logic [511:0] kd = '0;
    int           exp_q[$];
    int           total = 0;
    int           bad = 0;

    key_event_fifo #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .evt_ready   (evt_ready),
        .ovf_clr     (ovf_clr),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got %0d expected none", evt_code);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(evt_code) != e) begin
                    bad++;
                    $display("FAIL event_order: got %0d expected %0d", evt_code, e);
                end
            end
        end
    end

    // One decoder strobe; exp_code < 0 means no event is expected from it.
    task automatic strobe(input logic [8:0] code, input logic make, input logic rdy,
                          input int exp_code);
        @(posedge clk); #1;
        kd[code]    = make;
        key_down    = kd;
        last_change = code;
        key_valid   = 1'b1;
        evt_ready   = rdy;
        if (exp_code >= 0) exp_q.push_back(exp_code);
        @(posedge clk); #1;
        key_valid = 1'b0;
        evt_ready = 1'b0;
    endtask

    task automatic tap(input logic [8:0] code, input int exp_code);
        strobe(code, 1'b1, 1'b0, exp_code);
        strobe(code, 1'b0, 1'b0, -1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        evt_ready = 1'b1;
        while (count != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        evt_ready = 1'b0;
        chk({name, "_drained"}, int'(count), 0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int kp_exp;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_valid", int'(evt_valid), 0);
        chk("reset_code", int'(evt_code), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_ovf", int'(overflow), 0);

        // Single press: event one cycle after the make strobe, break ignored.
        strobe(9'h016, 1'b1, 1'b0, 1);
        chk("single_latency_valid", int'(evt_valid), 1);
        chk("single_latency_code", int'(evt_code), 1);
        strobe(9'h016, 1'b0, 1'b0, -1);
        chk("single_break_count", int'(count), 1);
        drain("single");

        // Typematic repeat.
        strobe(9'h05A, 1'b1, 1'b0, 10);
        strobe(9'h05A, 1'b1, 1'b0, -1);
        strobe(9'h05A, 1'b1, 1'b0, -1);
        chk("repeat_count", int'(count), 1);
        strobe(9'h05A, 1'b0, 1'b0, -1);
        drain("repeat");

        // Chord.
        strobe(9'h016, 1'b1, 1'b0, 1);
        strobe(9'h01E, 1'b1, 1'b0, -1);
        chk("chord_count", int'(count), 1);
        strobe(9'h016, 1'b0, 1'b0, -1);
        strobe(9'h01E, 1'b0, 1'b0, -1);
        tap(9'h01E, 2);
        chk("chord_after_count", int'(count), 2);
        drain("chord");

        // Overflow: fifth digit dropped, contents preserved.
        tap(9'h026, 3);
        tap(9'h025, 4);
        tap(9'h02E, 5);
        tap(9'h036, 6);
        chk("ovf_before", int'(overflow), 0);
        strobe(9'h03D, 1'b1, 1'b0, -1);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 4);
        strobe(9'h03D, 1'b0, 1'b0, -1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("ovf_clr", int'(overflow), 0);
        drain("ovf");

        // Full with simultaneous pop: new entry accepted, no overflow.
        tap(9'h016, 1);
        tap(9'h01E, 2);
        tap(9'h026, 3);
        tap(9'h025, 4);
        strobe(9'h046, 1'b1, 1'b1, 9);
        chk("fullpop_count", int'(count), 4);
        chk("fullpop_ovf", int'(overflow), 0);
        strobe(9'h046, 1'b0, 1'b0, -1);
        drain("fullpop");

        // Keypad 0.
`ifdef KEY_EVENT_KEYPAD_EN
        kp_exp = 0;
`else
        kp_exp = -1;
`endif
        tap(9'h070, kp_exp);
        chk("keypad_count", int'(count), (kp_exp >= 0) ? 1 : 0);
        drain("keypad");

        // Asynchronous reset mid-operation.
        tap(9'h02E, 5);
        strobe(9'h036, 1'b1, 1'b0, 6);
        chk("prereset_count", int'(count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", int'(evt_valid), 0);
        chk("async_reset_count", int'(count), 0);
        exp_q.delete();
        kd = '0;
        key_down = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        strobe(9'h045, 1'b1, 1'b0, 0);
        chk("post_reset_valid", int'(evt_valid), 1);
        chk("post_reset_count", int'(count), 1);
        strobe(9'h045, 1'b0, 1'b0, -1);
        drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
